// File: rtl/pkt_dispatch_sched.sv
// Packet dispatcher: round-robin picks one enabled+ready channel per packet and streams it through.
// Latency: one IDLE cycle plus one ARB cycle before the first beat; beats then pass through combinationally, one per clk.
// Backpressure: in_rdy follows chn_rdy of the granted channel during a packet; held low while arbitrating.
// Ports:
//   clk, rst_n                      - single clock, synchronous active-low reset
//   in_vld/in_sop/in_eop/in_dat     - input beat stream; in_rdy accepts a beat when high with in_vld
//   chn_en, chn_rdy                 - per-channel enable mask and downstream ready
//   dmx_sel, dmx_dat                - demux select (held for the whole packet) and beat data
//   out_vld, out_sop, out_eop       - one-hot per-channel valid and packet delimiters
//   err_cnt                         - saturating count of framing errors
module pkt_dispatch_sched #(
  parameter int CHN_NUM = 6,
  parameter int DWID    = 256,
  parameter int NUMWID  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [DWID-1:0]    in_dat,
  output logic               in_rdy,
  input  logic [CHN_NUM-1:0] chn_en,
  input  logic [CHN_NUM-1:0] chn_rdy,
  output logic [NUMWID-1:0]  dmx_sel,
  output logic [DWID-1:0]    dmx_dat,
  output logic [CHN_NUM-1:0] out_vld,
  output logic               out_sop,
  output logic               out_eop,
  output logic [15:0]        err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUMWID-1:0]  gnt;
  logic [NUMWID-1:0]  last_gnt;
  logic [NUMWID-1:0]  pick;
  logic               pick_vld;
  logic [CHN_NUM-1:0] eligible;
  logic               first_beat;
  logic               accept;
  logic               idle_err;
  logic               sop_err;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    logic [NUMWID-1:0] idx_w;
    eligible = chn_en & chn_rdy;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int i = 1; i <= CHN_NUM; i++) begin
      idx = int'(last_gnt) + i;
      if (idx >= CHN_NUM) idx = idx - CHN_NUM;
      idx_w = idx[NUMWID-1:0];
      if (!pick_vld && eligible[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_vld && in_sop) state_nxt = S_ARB;
      S_ARB:   if (pick_vld) state_nxt = S_XFER;
      S_XFER:  if (accept && in_eop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; everything is forced quiet while reset is asserted.
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = '0;
    dmx_dat = '0;
    out_sop = 1'b0;
    out_eop = 1'b0;
    if (rst_n) begin
      case (state)
        // A sop beat is left waiting for arbitration; anything else is swallowed.
        S_IDLE: in_rdy = !in_sop;
        S_XFER: begin
          in_rdy  = chn_rdy[gnt];
          out_vld = in_vld ? (CHN_NUM'(1) << gnt) : '0;
          dmx_dat = in_dat;
          out_sop = in_sop;
          out_eop = in_eop;
        end
        default: ;
      endcase
    end
  end

  assign accept   = in_vld && in_rdy;
  assign idle_err = (state == S_IDLE) && in_vld && !in_sop;
  // A sop after the first beat of a packet is passed through but flagged.
  assign sop_err  = (state == S_XFER) && accept && in_sop && !first_beat;

  // Grant, round-robin pointer and error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt        <= '0;
      dmx_sel    <= '0;
      last_gnt   <= NUMWID'(CHN_NUM - 1);
      err_cnt    <= '0;
      first_beat <= 1'b0;
    end else begin
      if (state == S_ARB && pick_vld) begin
        gnt        <= pick;
        dmx_sel    <= pick;
        first_beat <= 1'b1;
      end
      if (state == S_XFER && accept) begin
        first_beat <= 1'b0;
        if (in_eop) last_gnt <= gnt;
      end
      if ((idle_err || sop_err) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_dispatch_sched.sv
module tb_pkt_dispatch_sched;
  localparam int CHN_NUM = 6;
  localparam int DWID    = 256;
  localparam int NUMWID  = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_vld;
  logic               in_sop;
  logic               in_eop;
  logic [DWID-1:0]    in_dat;
  logic               in_rdy;
  logic [CHN_NUM-1:0] chn_en;
  logic [CHN_NUM-1:0] chn_rdy;
  logic [NUMWID-1:0]  dmx_sel;
  logic [DWID-1:0]    dmx_dat;
  logic [CHN_NUM-1:0] out_vld;
  logic               out_sop;
  logic               out_eop;
  logic [15:0]        err_cnt;

  always #5 clk = ~clk;

  pkt_dispatch_sched #(.CHN_NUM(CHN_NUM), .DWID(DWID), .NUMWID(NUMWID)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_dat(in_dat), .in_rdy(in_rdy),
    .chn_en(chn_en), .chn_rdy(chn_rdy),
    .dmx_sel(dmx_sel), .dmx_dat(dmx_dat), .out_vld(out_vld),
    .out_sop(out_sop), .out_eop(out_eop), .err_cnt(err_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;
  bit rnd_ctl     = 1'b0;

  task automatic chk(input string name, input logic [DWID-1:0] act, input logic [DWID-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 = waiting for a packet, 1 = packet waiting for a channel,
  // 2 = packet streaming to channel m_ch.
  int m_mode, m_ch, m_last, m_err, m_sel;
  bit m_first;

  initial begin : monitor
    bit armed;
    logic [CHN_NUM-1:0] el;
    logic [CHN_NUM-1:0] ev;
    logic               er;
    logic [DWID-1:0]    ed;
    int c;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (armed) begin
        ev = '0; er = 1'b0; ed = '0;
        if (rst_n) begin
          if (m_mode == 2) begin
            er = chn_rdy[m_ch[NUMWID-1:0]];
            if (in_vld) ev[m_ch[NUMWID-1:0]] = 1'b1;
            ed = in_dat;
          end else if (m_mode == 0) begin
            er = !in_sop;
          end
        end
        chk("in_rdy",  DWID'(in_rdy),  DWID'(er));
        chk("out_vld", DWID'(out_vld), DWID'(ev));
        chk("dmx_dat", dmx_dat, ed);
        if (!rst_n) begin
          chk("out_sop in reset", DWID'(out_sop), '0);
          chk("out_eop in reset", DWID'(out_eop), '0);
        end else if (m_mode == 2) begin
          chk("out_sop", DWID'(out_sop), DWID'(in_sop));
          chk("out_eop", DWID'(out_eop), DWID'(in_eop));
        end
        chk("dmx_sel", DWID'(dmx_sel), DWID'(m_sel));
        chk("err_cnt", DWID'(err_cnt), DWID'(m_err));
        if (rst_n && out_vld != '0 && in_rdy) delivered++;
      end
      if (!rst_n) begin
        m_mode = 0; m_last = CHN_NUM - 1; m_err = 0; m_sel = 0; m_ch = 0; m_first = 1'b0;
      end else begin
        case (m_mode)
          0: begin
            if (in_vld && in_sop) m_mode = 1;
            else if (in_vld && m_err < 65535) m_err++;
          end
          1: begin
            el = chn_en & chn_rdy;
            if (el != '0) begin
              for (int k = 1; k <= CHN_NUM; k++) begin
                c = (m_last + k) % CHN_NUM;
                if (el[c[NUMWID-1:0]]) begin
                  m_ch = c;
                  break;
                end
              end
              m_sel = m_ch; m_mode = 2; m_first = 1'b1;
            end
          end
          default: begin
            if (in_vld && chn_rdy[m_ch[NUMWID-1:0]]) begin
              if (in_sop && !m_first && m_err < 65535) m_err++;
              m_first = 1'b0;
              if (in_eop) begin
                m_last = m_ch; m_mode = 0;
              end
            end
          end
        endcase
      end
      if (!rst_n) armed = 1'b1;
    end
  end

  task automatic randomize_ctl();
    logic [CHN_NUM-1:0] v;
    v = CHN_NUM'($urandom() | $urandom());
    chn_en = (v == '0) ? CHN_NUM'(1) : v;
    v = CHN_NUM'($urandom() | $urandom());
    chn_rdy = v;
  endtask

  task automatic drive_beat(input bit sop, input bit eop);
    in_vld = 1'b1; in_sop = sop; in_eop = eop;
    for (int i = 0; i < DWID / 32; i++) in_dat[i*32 +: 32] = $urandom();
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_vld && in_rdy;
    @(posedge clk);
    #1;
    if (rnd_ctl) randomize_ctl();
  endtask

  task automatic send_pkt(input int nb, input int sop_beat, input int stall_beat,
                          output int gch, output int first_wait, output int stalls);
    bit acc;
    int cyc;
    logic [CHN_NUM-1:0] save;
    logic [NUMWID-1:0]  gi;
    gch = -1; first_wait = 0; stalls = 0;
    for (int b = 0; b < nb; b++) begin
      if (rnd_ctl && b > 0 && $urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        step(acc);
      end
      drive_beat(b == 0 || b == sop_beat, b == nb - 1);
      acc = 1'b0; cyc = 0;
      if (b == stall_beat && gch >= 0) begin
        save = chn_rdy;
        gi = gch[NUMWID-1:0];
        chn_rdy[gi] = 1'b0;
        for (int k = 0; k < 3 && !acc; k++) begin
          step(acc);
          if (!acc) stalls++;
        end
        chn_rdy = save;
      end
      while (!acc && cyc < 1000) begin
        step(acc);
        cyc++;
        if (!acc && b == 0) first_wait++;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL send_pkt timeout: beat %0d never accepted, expected acceptance within 1000 cycles", b);
        in_vld = 1'b0;
        return;
      end
      if (b == 0) gch = int'(dmx_sel);
    end
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g, w, s, d0, n, nb, sb, exp_del;
    bit acc;
    rst_n = 1'b0; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_dat = '0;
    chn_en = '1; chn_rdy = '1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state: outputs quiet even with a stray beat presented
    drive_beat(1'b0, 1'b0);
    @(negedge clk);
    chk("reset in_rdy", DWID'(in_rdy), '0);
    chk("reset out_vld", DWID'(out_vld), '0);
    chk("reset dmx_dat", dmx_dat, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_vld = 1'b0;
    @(negedge clk);
    chk("reset err_cnt", DWID'(err_cnt), '0);
    chk("reset dmx_sel", DWID'(dmx_sel), '0);
    @(posedge clk); #1;

    // Three back-to-back packets, everything enabled: 0,1,2
    for (int p = 0; p < 3; p++) begin
      send_pkt(4, -1, -1, g, w, s);
      chk("A grant", DWID'(g), DWID'(p));
      chk("A wait before first beat", DWID'(w), DWID'(2));
    end
    @(negedge clk);
    chk("A err_cnt", DWID'(err_cnt), '0);
    @(posedge clk); #1;

    // Sparse enable mask with last grant 2: 5 then wrap to 2
    chn_en = 6'b100100;
    send_pkt(2, -1, -1, g, w, s);
    chk("B grant 1", DWID'(g), DWID'(5));
    send_pkt(2, -1, -1, g, w, s);
    chk("B grant 2", DWID'(g), DWID'(2));
    chn_en = '1;

    // Downstream stall of 3 cycles mid-packet
    d0 = delivered;
    send_pkt(4, -1, 2, g, w, s);
    chk("C grant", DWID'(g), DWID'(3));
    chk("C stall cycles", DWID'(s), DWID'(3));
    chk("C beats delivered", DWID'(delivered - d0), DWID'(4));
    chk("C dmx_sel held", DWID'(dmx_sel), DWID'(3));

    // Nothing eligible for 5 ARB cycles, then channel 4 becomes ready
    chn_rdy = '0;
    drive_beat(1'b1, 1'b1);
    n = 0;
    repeat (6) begin
      step(acc);
      if (acc) n++;
    end
    chk("D beats taken while blocked", DWID'(n), '0);
    chn_rdy = 6'b010000;
    send_pkt(1, -1, -1, g, w, s);
    chk("D grant", DWID'(g), DWID'(4));
    chk("D wait after ready", DWID'(w), DWID'(1));
    chn_rdy = '1;

    // Two stray beats while idle, then a one-beat packet
    drive_beat(1'b0, 1'b0); step(acc);
    chk("E stray 1 taken", DWID'(acc), DWID'(1));
    drive_beat(1'b0, 1'b1); step(acc);
    chk("E stray 2 taken", DWID'(acc), DWID'(1));
    d0 = delivered;
    send_pkt(1, -1, -1, g, w, s);
    chk("E single-beat grant", DWID'(g), DWID'(5));
    chk("E single-beat delivered", DWID'(delivered - d0), DWID'(1));
    @(negedge clk);
    chk("E err_cnt", DWID'(err_cnt), DWID'(2));
    @(posedge clk); #1;
    // Back in idle: a stray beat is swallowed even with no channel ready
    chn_rdy = '0;
    drive_beat(1'b0, 1'b0); step(acc);
    chk("E idle after packet", DWID'(acc), DWID'(1));
    in_vld = 1'b0; chn_rdy = '1;
    @(negedge clk);
    chk("E err_cnt after stray", DWID'(err_cnt), DWID'(3));
    @(posedge clk); #1;

    // Reset during beat 2 of a 4-beat packet on channel 1
    chn_en = 6'b000010;
    drive_beat(1'b1, 1'b0);
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin step(acc); n++; end
    chk("F first beat taken", DWID'(acc), DWID'(1));
    chk("F grant", DWID'(dmx_sel), DWID'(1));
    drive_beat(1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("F reset in_rdy", DWID'(in_rdy), '0);
    chk("F reset out_vld", DWID'(out_vld), '0);
    chk("F reset dmx_dat", dmx_dat, '0);
    chk("F reset out_sop", DWID'(out_sop), '0);
    chk("F reset out_eop", DWID'(out_eop), '0);
    @(posedge clk); #1;
    rst_n = 1'b1; chn_en = '1;
    drive_beat(1'b0, 1'b0);
    @(negedge clk);
    chk("F err_cnt cleared", DWID'(err_cnt), '0);
    chk("F dmx_sel cleared", DWID'(dmx_sel), '0);
    chk("F beat 3 discarded", DWID'(in_rdy), DWID'(1));
    @(posedge clk); #1;
    drive_beat(1'b0, 1'b1); step(acc);
    chk("F beat 4 discarded", DWID'(acc), DWID'(1));
    in_vld = 1'b0;
    @(negedge clk);
    chk("F err_cnt", DWID'(err_cnt), DWID'(2));
    @(posedge clk); #1;
    send_pkt(2, -1, -1, g, w, s);
    chk("F grant after reset", DWID'(g), '0);

    // Randomized traffic checked cycle by cycle by the monitor
    rnd_ctl = 1'b1;
    d0 = delivered; exp_del = 0;
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive_beat(1'b0, 1'($urandom_range(0, 1)));
        step(acc);
      end
      if ($urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        step(acc);
      end
      nb = $urandom_range(1, 6);
      sb = (nb > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb - 1) : -1;
      send_pkt(nb, sb, -1, g, w, s);
      exp_del += nb;
    end
    rnd_ctl = 1'b0;
    in_vld = 1'b0;
    chk("random beats delivered", DWID'(delivered - d0), DWID'(exp_del));
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
